// File: rtl/lane_unstriper.sv
// rtl/lane_unstriper.sv - reassembles a 4-slot serial byte stream into four parallel lanes
//
// Purpose:
//   One byte slot arrives per clk_1 cycle. A group is four consecutive slots,
//   and sog marks slot 0. Slots 0..2 are held in shadow registers. On the edge
//   that captures slot 3, all four lanes are loaded at once and group_strobe
//   pulses. Framing violations pulse sync_err and leave the lane outputs
//   unchanged.
//
// Ports:
//   clk_1                 in   sole clock, rising edge
//   reset                 in   asynchronous, active-high
//   data_in[7:0]          in   byte for the current slot
//   valid_in              in   data_in is valid for this slot
//   sog                   in   start of group (slot 0 marker)
//   parity_in             in   even parity of data_in (UNSTRIPE_PARITY_EN only)
//   dataOut0..3[7:0]      out  lane bytes of the last completed group
//   validOut0..3          out  lane valids of the last completed group
//   group_strobe          out  one-cycle pulse when the lanes are reloaded
//   sync_err              out  one-cycle pulse on a framing violation
//   parity_err            out  sticky parity error (UNSTRIPE_PARITY_EN only)
//
// Configuration:
//   UNSTRIPE_PARITY_EN    define to add parity_in / parity_err and the parity check

module lane_unstriper (
  input  logic       clk_1,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       sog,
`ifdef UNSTRIPE_PARITY_EN
  input  logic       parity_in,
  output logic       parity_err,
`endif
  output logic [7:0] dataOut0,
  output logic [7:0] dataOut1,
  output logic [7:0] dataOut2,
  output logic [7:0] dataOut3,
  output logic       validOut0,
  output logic       validOut1,
  output logic       validOut2,
  output logic       validOut3,
  output logic       group_strobe,
  output logic       sync_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [1:0]      slot_q;
  logic [2:0][7:0] shd_data_q;
  logic [2:0]      shd_valid_q;

  // An invalid slot is stored as 8'h00 no matter what data_in carries.
  logic [7:0] cap_data_d;
  assign cap_data_d = valid_in ? data_in : 8'h00;

`ifdef UNSTRIPE_PARITY_EN
  // A byte counts as captured exactly when it lands in a slot; bytes ignored
  // in IDLE and the byte dropped on a missing sog are not checked.
  logic capture_d;
  always_comb begin
    capture_d = 1'b0;
    if (state_q == IDLE || slot_q == 2'd0) begin
      capture_d = sog;
    end else begin
      capture_d = 1'b1;
    end
  end

  always_ff @(posedge clk_1 or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (capture_d && valid_in && (^{data_in, parity_in})) begin
      parity_err <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_1 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      slot_q       <= 2'd0;
      shd_data_q   <= '0;
      shd_valid_q  <= '0;
      dataOut0     <= 8'h00;
      dataOut1     <= 8'h00;
      dataOut2     <= 8'h00;
      dataOut3     <= 8'h00;
      validOut0    <= 1'b0;
      validOut1    <= 1'b0;
      validOut2    <= 1'b0;
      validOut3    <= 1'b0;
      group_strobe <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      group_strobe <= 1'b0;
      sync_err     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sog) begin
            shd_data_q[0]  <= cap_data_d;
            shd_valid_q[0] <= valid_in;
            slot_q         <= 2'd1;
            state_q        <= RUN;
          end
        end
        RUN: begin
          if (slot_q == 2'd0) begin
            if (sog) begin
              shd_data_q[0]  <= cap_data_d;
              shd_valid_q[0] <= valid_in;
              slot_q         <= 2'd1;
            end else begin
              // Lost framing: drop the byte and wait for the next sog.
              sync_err <= 1'b1;
              slot_q   <= 2'd0;
              state_q  <= IDLE;
            end
          end else if (sog) begin
            // Early sog: the partial group is abandoned and this byte restarts
            // the group. Stale shadow slots 1..2 are overwritten before use.
            sync_err       <= 1'b1;
            shd_data_q[0]  <= cap_data_d;
            shd_valid_q[0] <= valid_in;
            slot_q         <= 2'd1;
          end else if (slot_q == 2'd3) begin
            // Slot 3 bypasses the shadow and goes straight to lane 3 so the
            // whole group becomes visible on this edge.
            dataOut0     <= shd_data_q[0];
            dataOut1     <= shd_data_q[1];
            dataOut2     <= shd_data_q[2];
            dataOut3     <= cap_data_d;
            validOut0    <= shd_valid_q[0];
            validOut1    <= shd_valid_q[1];
            validOut2    <= shd_valid_q[2];
            validOut3    <= valid_in;
            group_strobe <= 1'b1;
            slot_q       <= 2'd0;
          end else begin
            shd_data_q[slot_q]  <= cap_data_d;
            shd_valid_q[slot_q] <= valid_in;
            slot_q              <= slot_q + 2'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          slot_q  <= 2'd0;
        end
      endcase
    end
  end

endmodule
